// File: rtl/div4_seq.sv
// rtl/div4_seq.sv - sequential restoring unsigned divider, one quotient bit per cycle
// Optional macro DIV4_SEQ_ZERO_FAST_EN: divisor==0 skips RUN and completes in one cycle.
module div4_seq #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  localparam int CW = $clog2(WIDTH) + 1;
  localparam logic [WIDTH:0] ONE = (WIDTH+1)'(1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state, state_nxt;
  logic [CW-1:0]    cnt;
  logic [WIDTH:0]   r_work;
  logic [WIDTH-1:0] q_work;
  logic [WIDTH-1:0] dvs;
  logic [2*WIDTH:0] shifted;
  logic [WIDTH:0]   r_sh;
  logic [WIDTH:0]   trial;
  logic [WIDTH:0]   r_step;
  logic [WIDTH-1:0] q_step;
  logic             last_step;
  logic             zero_fast;

  assign last_step = (cnt == CW'(WIDTH - 1));
  assign busy      = (state == RUN);
  assign done      = (state == DONE);

`ifdef DIV4_SEQ_ZERO_FAST_EN
  assign zero_fast = (divisor == '0);
`else
  assign zero_fast = 1'b0;
`endif

  // Restoring step: the sign of the (WIDTH+1)-bit trial decides whether to keep it.
  always_comb begin
    shifted = {r_work, q_work} << 1;
    r_sh    = shifted[2*WIDTH:WIDTH];
    trial   = r_sh + ~{1'b0, dvs} + ONE;
    if (!trial[WIDTH]) begin
      r_step = trial;
      q_step = {shifted[WIDTH-1:1], 1'b1};
    end else begin
      r_step = r_sh;
      q_step = shifted[WIDTH-1:0];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = zero_fast ? DONE : RUN;
      RUN:     if (last_step) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt         <= '0;
      r_work      <= '0;
      q_work      <= '0;
      dvs         <= '0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            dvs    <= divisor;
            q_work <= dividend;
            r_work <= '0;
            cnt    <= '0;
            if (zero_fast) begin
              quotient    <= '1;
              remainder   <= dividend;
              div_by_zero <= 1'b1;
            end
          end
        end
        RUN: begin
          r_work <= r_step;
          q_work <= q_step;
          cnt    <= cnt + CW'(1);
          // Results are captured on the final step so they stay put through IDLE.
          if (last_step) begin
            quotient    <= q_step;
            remainder   <= r_step[WIDTH-1:0];
            div_by_zero <= (dvs == '0);
          end
        end
        default: ;
      endcase
    end
  end

endmodule
